// File: rtl/axis_pkg.sv
// Shared types and defaults for the AXI-Stream master/slave codebase.
package axis_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } fsm_state_t;

  localparam int DEFAULT_DATA_W     = 8;
  localparam int DEFAULT_FIFO_DEPTH = 16;

endpackage

// File: rtl/axis_master_if.sv
// AXI-Stream bus bundle: master drives tdata/tvalid/tlast, slave drives tready.
interface axis_master_if
  import axis_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_fifo.sv
// Synchronous FIFO with show-ahead read port; depth must be a power of two.
// Writes while full and reads while empty are ignored.
module axis_fifo
  import axis_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_wr;
  logic              do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/axis_master.sv
// AXI-Stream transmitter: bytes queued in a local FIFO are sent as a packet of
// pkt_len beats on start, with tlast on the final beat and full tready
// back-pressure support. All stream outputs are registered.
// Optional macro AXIS_MASTER_PKT_CNT_EN adds a 16-bit completed-packet counter.
module axis_master
  import axis_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int LEN_W      = 8
) (
  input  logic              m_axis_aclk,
  input  logic              m_axis_arst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  input  logic              start,
  input  logic [LEN_W-1:0]  pkt_len,
  output logic              busy,
  axis_master_if.master     m_axis
`ifdef AXIS_MASTER_PKT_CNT_EN
  ,
  output logic [15:0]       pkt_cnt
`endif
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_SEND = SEND;

  logic [0:0]        state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued_q;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              load;
  logic              last_hs;

  // The output register may take a new beat when it is empty or being drained
  // this cycle; tready never reaches tvalid without passing through a flop.
  assign load    = (state == ST_SEND) && (!m_axis.tvalid || m_axis.tready) &&
                   !empty && (issued_q != len_q);
  assign last_hs = m_axis.tvalid && m_axis.tready && m_axis.tlast;
  assign busy    = (state == ST_SEND);

  axis_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (m_axis_aclk),
    .rst    (m_axis_arst),
    .wr_data(wr_data),
    .wr_en  (wr_en),
    .rd_en  (load),
    .rd_data(fifo_rd_data),
    .full   (full),
    .empty  (empty)
  );

  // Packet control: latch the length on start, count issued beats, and return
  // to IDLE once the tlast beat has been accepted by the sink.
  always_ff @(posedge m_axis_aclk or posedge m_axis_arst) begin
    if (m_axis_arst) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      issued_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && (pkt_len != '0)) begin
            len_q    <= pkt_len;
            issued_q <= '0;
            state    <= ST_SEND;
          end
        end
        default: begin
          if (load)    issued_q <= issued_q + 1'b1;
          if (last_hs) state    <= ST_IDLE;
        end
      endcase
    end
  end

  // Stream output register: load the FIFO head, or drop tvalid when the
  // register is free and nothing is loadable (bubble or end of packet).
  always_ff @(posedge m_axis_aclk or posedge m_axis_arst) begin
    if (m_axis_arst) begin
      m_axis.tdata  <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
    end else if (load) begin
      m_axis.tdata  <= fifo_rd_data;
      m_axis.tvalid <= 1'b1;
      m_axis.tlast  <= (issued_q == (len_q - 1'b1));
    end else if (!m_axis.tvalid || m_axis.tready) begin
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
    end
  end

`ifdef AXIS_MASTER_PKT_CNT_EN
  // Completed-packet counter, wrapping at 16 bits.
  always_ff @(posedge m_axis_aclk or posedge m_axis_arst) begin
    if (m_axis_arst) begin
      pkt_cnt <= '0;
    end else if (last_hs) begin
      pkt_cnt <= pkt_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_master.sv
// Testbench for axis_master: a queue-based reference model of the pushed bytes
// and the outstanding packet, a negedge monitor comparing every accepted beat
// and every stall cycle, plus directed literal checks per scenario.
module tb_axis_master;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int LW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic          full;
  logic          empty;
  logic          start = 1'b0;
  logic [LW-1:0] pkt_len = '0;
  logic          busy;
`ifdef AXIS_MASTER_PKT_CNT_EN
  logic [15:0]   pkt_cnt;
`endif

  axis_master_if #(.DATA_W(DW)) m_axis ();

  axis_master #(
    .DATA_W    (DW),
    .FIFO_DEPTH(DEPTH),
    .LEN_W     (LW)
  ) dut (
    .m_axis_aclk(clk),
    .m_axis_arst(rst),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .full       (full),
    .empty      (empty),
    .start      (start),
    .pkt_len    (pkt_len),
    .busy       (busy),
    .m_axis     (m_axis)
`ifdef AXIS_MASTER_PKT_CNT_EN
    ,
    .pkt_cnt    (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] mq[$];
  int            exp_left = 0;
  int            beat_count = 0;
  int            tlast_count = 0;
  int            first_cyc = 0;
  int            last_cyc = 0;
  int            cyc = 0;
  logic [DW-1:0] last_data = '0;
  logic [DW-1:0] exp_d;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  bit   [3:0]    pat = 4'b1001;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a beat is accepted at the next rising edge when tvalid && tready
  // are both high at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("stall_hold", {m_axis.tvalid, m_axis.tlast, m_axis.tdata},
              {1'b1, prev_last, prev_data});
      if (m_axis.tvalid)
        check("busy_with_tvalid", busy, 1);
      if (m_axis.tvalid && m_axis.tready) begin
        if (exp_left == 0 || mq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: tdata %0h with no beat outstanding", m_axis.tdata);
        end else begin
          exp_d = mq.pop_front();
          check("beat_data", m_axis.tdata, exp_d);
          check("beat_last", m_axis.tlast, (exp_left == 1));
          exp_left--;
        end
        beat_count++;
        if (m_axis.tlast) tlast_count++;
        if (beat_count == 1) first_cyc = cyc;
        last_cyc  = cyc;
        last_data = m_axis.tdata;
      end
      stall_prev = m_axis.tvalid && !m_axis.tready;
      prev_data  = m_axis.tdata;
      prev_last  = m_axis.tlast;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] b);
    wr_data = b;
    wr_en   = 1'b1;
    if (mq.size() < DEPTH) mq.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_pkt(input int len);
    start   = 1'b1;
    pkt_len = LW'(len);
    if (len != 0 && !busy) exp_left = len;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    check("idle_reached", busy, 0);
    check("pkt_all_beats", exp_left, 0);
  endtask

  task automatic clear_stats();
    beat_count  = 0;
    tlast_count = 0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    mq.delete();
    exp_left = 0;
    tick(2);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_axis.tready = 1'b1;
    #12;
    check("rst_tvalid", m_axis.tvalid, 0);
    check("rst_tlast", m_axis.tlast, 0);
    check("rst_tdata", m_axis.tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // 10-beat packet, sink always ready
    clear_stats();
    for (int i = 0; i < 10; i++) push(DW'(8'h11 + i));
    start_pkt(10);
    check("lat_busy", busy, 1);
    check("lat_tvalid_early", m_axis.tvalid, 0);
    tick();
    check("lat_tvalid", m_axis.tvalid, 1);
    check("lat_first_data", m_axis.tdata, 8'h11);
    wait_idle(50);
    check("p10_beats", beat_count, 10);
    check("p10_tlast_cnt", tlast_count, 1);
    check("p10_last_data", last_data, 8'h1A);
    check("p10_back_to_back", last_cyc - first_cyc, 9);
    check("p10_empty", empty, 1);

    // 4-beat packet with tready pattern 1,0,0,1
    clear_stats();
    for (int i = 0; i < 4; i++) push(DW'(8'h21 + i));
    start_pkt(4);
    for (int i = 0; i < 40 && busy; i++) begin
      m_axis.tready = pat[i % 4];
      tick();
    end
    m_axis.tready = 1'b1;
    check("bp_idle", busy, 0);
    check("bp_beats", beat_count, 4);
    check("bp_tlast_cnt", tlast_count, 1);
    check("bp_last_data", last_data, 8'h24);

    // Bubble: only 2 of 4 bytes queued at start
    clear_stats();
    push(8'h31);
    push(8'h32);
    start_pkt(4);
    tick(5);
    check("bub_tvalid", m_axis.tvalid, 0);
    check("bub_busy", busy, 1);
    check("bub_beats", beat_count, 2);
    push(8'h33);
    push(8'h34);
    wait_idle(50);
    check("bub_total", beat_count, 4);
    check("bub_tlast_cnt", tlast_count, 1);
    check("bub_last_data", last_data, 8'h34);

    // Fill FIFO, overflow write dropped
    clear_stats();
    for (int i = 0; i < 16; i++) push(DW'(8'h40 + i));
    check("fill_full", full, 1);
    check("fill_empty", empty, 0);
    push(8'hFF);
    check("ovf_full", full, 1);
    start_pkt(16);
    wait_idle(100);
    check("ovf_beats", beat_count, 16);
    check("ovf_last_data", last_data, 8'h4F);
    check("ovf_empty", empty, 1);
    check("ovf_full_clear", full, 0);

    // Zero-length start ignored, then a 1-beat packet
    clear_stats();
    start_pkt(0);
    tick(3);
    check("zero_busy", busy, 0);
    check("zero_beats", beat_count, 0);
    push(8'h5A);
    start_pkt(1);
    wait_idle(20);
    check("one_beats", beat_count, 1);
    check("one_data", last_data, 8'h5A);
    check("one_tlast_cnt", tlast_count, 1);

`ifdef AXIS_MASTER_PKT_CNT_EN
    // Packet counter
    pulse_reset();
    check("cnt_reset", pkt_cnt, 0);
    for (int p = 0; p < 3; p++) begin
      push(DW'(8'h60 + p));
      push(DW'(8'h70 + p));
      start_pkt(2);
      wait_idle(20);
    end
    check("cnt_three", pkt_cnt, 3);
    start_pkt(0);
    tick(3);
    check("cnt_zero_len", pkt_cnt, 3);
    check("cnt_zero_busy", busy, 0);
`endif

    // Reset after beat 2 of 6
    clear_stats();
    for (int i = 0; i < 6; i++) push(DW'(8'h81 + i));
    start_pkt(6);
    for (int n = 0; n < 50 && beat_count < 2; n++) tick();
    check("mid_beats", beat_count, 2);
    #2;
    rst = 1'b1;
    mq.delete();
    exp_left = 0;
    #1;
    check("mid_tvalid", m_axis.tvalid, 0);
    check("mid_tlast", m_axis.tlast, 0);
    check("mid_tdata", m_axis.tdata, 0);
    check("mid_busy", busy, 0);
    check("mid_empty", empty, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    clear_stats();
    start_pkt(6);
    tick(10);
    check("post_rst_beats", beat_count, 0);
    check("post_rst_tvalid", m_axis.tvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
